seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_pkg.sv | 19 +
 rtl/seg_bcd_dec.sv | 11 +
 rtl/seg_scan_ctrl.sv | 172 +++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the multiplexed 4-digit seven-segment scanner.
// Leading-zero blanking lives in seg_scan_ctrl and is enabled by the SEG_LZB_EN macro.
package seg_scan_pkg;

   localparam int DIGIT_CNT = 4;

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } scan_state_t;

   // Segments a..g, bit0 = a; codes 10..15 blank like a 4511
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00
   };

endpackage

// File: rtl/seg_bcd_dec.sv
// Combinational BCD nibble to seven-segment decoder (active-high, Y[0] = a).
module seg_bcd_dec
   import seg_scan_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   assign seg = SEG_TABLE[nib];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with frame-synchronous value update.
// Define SEG_LZB_EN to blank leading zeros on dig4..dig2.
module seg_scan_ctrl
   import seg_scan_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 1000,
   parameter int unsigned DEAD_CYC = 8
) (
   input  logic        CP,
   input  logic        MR,
   input  logic        en_i,
   input  logic [15:0] val_i,
   input  logic [3:0]  dp_i,
   input  logic        load_i,
   output logic        pend_o,
   output logic [6:0]  Y,
   output logic        dig1,
   output logic        dig2,
   output logic        dig3,
   output logic        dig4,
   output logic        dp,
   output logic        frame_o
);

   // state | meaning
   // OFF   | scanning disabled, all digits dark
   // BLANK | DEAD_CYC cycles with all digits dark between slots
   // SHOW  | SCAN_DIV cycles with digit idx lit

   localparam logic [15:0] SHOW_LAST = 16'(SCAN_DIV - 1);
   localparam logic [7:0]  DEAD_LAST = 8'(DEAD_CYC - 1);
   localparam logic [1:0]  IDX_LAST  = 2'(DIGIT_CNT - 1);

   scan_state_t state;
   logic [1:0]  idx;
   logic [15:0] show_cnt;
   logic [7:0]  dead_cnt;

   logic [15:0] disp_val;
   logic [3:0]  disp_dp;
   logic [15:0] pend_val;
   logic [3:0]  pend_dp;

   logic        frame_edge;
   logic [3:0]  cur_nib;
   logic [6:0]  cur_seg;
   logic        cur_blank;
   logic [3:0]  dig_n;

   assign frame_edge = en_i && (state == ST_SHOW) && (show_cnt == 16'd0) && (idx == IDX_LAST);

   assign cur_nib = disp_val[{idx, 2'b00} +: 4];

   seg_bcd_dec u_dec (
      .nib (cur_nib),
      .seg (cur_seg)
   );

`ifdef SEG_LZB_EN
   // A digit is blanked when it and every nibble above it are zero
   always_comb begin
      cur_blank = 1'b0;
      case (idx)
         2'd3:    cur_blank = (disp_val[15:12] == 4'd0);
         2'd2:    cur_blank = (disp_val[15:8] == 8'd0);
         2'd1:    cur_blank = (disp_val[15:4] == 12'd0);
         default: cur_blank = 1'b0;
      endcase
   end
`else
   assign cur_blank = 1'b0;
`endif

   always_ff @(posedge CP or negedge MR) begin
      if (!MR) begin
         state    <= ST_OFF;
         idx      <= 2'd0;
         show_cnt <= 16'd0;
         dead_cnt <= 8'd0;
         frame_o  <= 1'b0;
         Y        <= 7'd0;
         dig_n    <= 4'hF;
         dp       <= 1'b1;
      end else begin
         frame_o <= frame_edge;

         // Outputs trail the state by one cycle and go dark one edge after en_i falls
         if (en_i && (state == ST_SHOW)) begin
            Y     <= cur_blank ? 7'd0 : cur_seg;
            dig_n <= ~(4'b0001 << idx);
            dp    <= ~disp_dp[idx];
         end else begin
            Y     <= 7'd0;
            dig_n <= 4'hF;
            dp    <= 1'b1;
         end

         if (!en_i) begin
            state    <= ST_OFF;
            idx      <= 2'd0;
            show_cnt <= 16'd0;
            dead_cnt <= 8'd0;
         end else begin
            case (state)
               ST_OFF: begin
                  state    <= ST_BLANK;
                  dead_cnt <= DEAD_LAST;
               end
               ST_BLANK: begin
                  if (dead_cnt == 8'd0) begin
                     state    <= ST_SHOW;
                     show_cnt <= SHOW_LAST;
                  end else begin
                     dead_cnt <= dead_cnt - 8'd1;
                  end
               end
               ST_SHOW: begin
                  if (show_cnt == 16'd0) begin
                     state    <= ST_BLANK;
                     idx      <= idx + 2'd1;
                     dead_cnt <= DEAD_LAST;
                  end else begin
                     show_cnt <= show_cnt - 16'd1;
                  end
               end
               default: begin
                  state <= ST_OFF;
                  idx   <= 2'd0;
               end
            endcase
         end
      end
   end

   // Pending value is held until the frame boundary so a frame never mixes two values
   always_ff @(posedge CP or negedge MR) begin
      if (!MR) begin
         disp_val <= 16'd0;
         disp_dp  <= 4'd0;
         pend_val <= 16'd0;
         pend_dp  <= 4'd0;
         pend_o   <= 1'b0;
      end else if (!en_i) begin
         if (load_i) begin
            disp_val <= val_i;
            disp_dp  <= dp_i;
         end else if (pend_o) begin
            disp_val <= pend_val;
            disp_dp  <= pend_dp;
         end
         pend_o <= 1'b0;
      end else begin
         if (frame_edge && pend_o) begin
            disp_val <= pend_val;
            disp_dp  <= pend_dp;
         end
         if (load_i) begin
            pend_val <= val_i;
            pend_dp  <= dp_i;
            pend_o   <= 1'b1;
         end else if (frame_edge) begin
            pend_o <= 1'b0;
         end
      end
   end

   assign dig1 = dig_n[0];
   assign dig2 = dig_n[1];
   assign dig3 = dig_n[2];
   assign dig4 = dig_n[3];

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: expected digit windows queued per frame and checked as they light.
module tb_seg_scan_ctrl;

   localparam int SCAN = 4;
   localparam int DEAD = 1;

   logic        CP = 1'b0;
   logic        MR = 1'b1;
   logic        en_i = 1'b0;
   logic [15:0] val_i = 16'd0;
   logic [3:0]  dp_i = 4'd0;
   logic        load_i = 1'b0;
   logic        pend_o;
   logic [6:0]  Y;
   logic        dig1, dig2, dig3, dig4;
   logic        dp;
   logic        frame_o;

   always #5 CP = ~CP;

   seg_scan_ctrl #(.SCAN_DIV(SCAN), .DEAD_CYC(DEAD)) dut (
      .CP      (CP),
      .MR      (MR),
      .en_i    (en_i),
      .val_i   (val_i),
      .dp_i    (dp_i),
      .load_i  (load_i),
      .pend_o  (pend_o),
      .Y       (Y),
      .dig1    (dig1),
      .dig2    (dig2),
      .dig3    (dig3),
      .dig4    (dig4),
      .dp      (dp),
      .frame_o (frame_o)
   );

   typedef struct packed {
      logic [3:0] dig_n;
      logic [6:0] y;
      logic       dp;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   skip_len = 1'b0;
   bit   skip_gap = 1'b1;
   int   frame_cnt = 0;
   int   frame_snap;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] seg_of(input logic [3:0] n);
      case (n)
         4'd0: return 7'h3F;
         4'd1: return 7'h06;
         4'd2: return 7'h5B;
         4'd3: return 7'h4F;
         4'd4: return 7'h66;
         4'd5: return 7'h6D;
         4'd6: return 7'h7D;
         4'd7: return 7'h07;
         4'd8: return 7'h7F;
         4'd9: return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   function automatic bit lzb_blank(input logic [15:0] v, input int i);
`ifdef SEG_LZB_EN
      return (i > 0) && ((v >> (4 * i)) == 16'd0);
`else
      return (i < 0) && (v == 16'd0);
`endif
   endfunction

   task automatic push_frame(input logic [15:0] v, input logic [3:0] dpv);
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         e.dig_n = ~(4'b0001 << i);
         e.y     = lzb_blank(v, i) ? 7'h00 : seg_of(v[i*4 +: 4]);
         e.dp    = ~dpv[i];
         sb_q.push_back(e);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge CP);
   endtask

   task automatic pulse_load(input logic [15:0] v, input logic [3:0] dpv);
      val_i  = v;
      dp_i   = dpv;
      load_i = 1'b1;
      @(negedge CP);
      load_i = 1'b0;
   endtask

   task automatic wait_frame(input string tag);
      int n = 0;
      do begin
         @(negedge CP);
         n++;
      end while (!frame_o && n < 60);
      check({tag, "_frame_seen"}, 16'(frame_o), 16'd1);
   endtask

   // Window monitor: pops one expectation per lit-digit window
   logic [3:0] dig_n_w;
   assign dig_n_w = {dig4, dig3, dig2, dig1};
   int   lit_len = 0;
   int   gap_len = 0;
   bit   was_lit = 1'b0;
   bit   was_frame = 1'b0;
   exp_t cur;

   always @(negedge CP) begin
      if (frame_o) begin
         frame_cnt++;
         check("frame_width", 16'(was_frame), 16'd0);
      end
      was_frame = frame_o;
      if (dig_n_w != 4'hF) begin
         if (!was_lit) begin
            if (!skip_gap) check("gap_len", 16'(gap_len), 16'(DEAD));
            skip_gap = 1'b0;
            if (sb_q.size() == 0) begin
               check("window_expected", 16'(dig_n_w), 16'hF);
            end else begin
               cur = sb_q.pop_front();
               check("win_dig", 16'(dig_n_w), 16'(cur.dig_n));
               check("win_y", 16'(Y), 16'(cur.y));
               check("win_dp", 16'(dp), 16'(cur.dp));
            end
            lit_len = 0;
         end
         lit_len++;
         was_lit = 1'b1;
      end else begin
         if (was_lit) begin
            if (!skip_len) check("lit_len", 16'(lit_len), 16'(SCAN));
            skip_len = 1'b0;
            gap_len = 0;
         end
         check("off_y", 16'(Y), 16'd0);
         check("off_dp", 16'(dp), 16'd1);
         gap_len++;
         was_lit = 1'b0;
      end
   end

   initial begin
      #1 MR = 1'b0;
      #2;
      check("rst_y", 16'(Y), 16'd0);
      check("rst_dig", 16'(dig_n_w), 16'hF);
      check("rst_dp", 16'(dp), 16'd1);
      check("rst_frame", 16'(frame_o), 16'd0);
      check("rst_pend", 16'(pend_o), 16'd0);
      cycles(3);
      MR = 1'b1;
      cycles(1);

      // Disabled load goes straight to display
      pulse_load(16'h1234, 4'h0);
      check("dis_load_pend", 16'(pend_o), 16'd0);
      push_frame(16'h1234, 4'h0);
      en_i = 1'b1;

      // Mid-frame load stays pending until the boundary
      cycles(7);
      pulse_load(16'h5678, 4'b0010);
      check("mid_load_pend", 16'(pend_o), 16'd1);
      wait_frame("f1");
      check("f1_pend_clr", 16'(pend_o), 16'd0);
      push_frame(16'h5678, 4'b0010);

      // Two loads in one frame: newest wins
      cycles(3);
      pulse_load(16'h1111, 4'h0);
      cycles(5);
      pulse_load(16'h2222, 4'h0);
      check("two_load_pend", 16'(pend_o), 16'd1);
      wait_frame("f2");
      check("f2_pend_clr", 16'(pend_o), 16'd0);
      push_frame(16'h2222, 4'h0);

      // Pending 0C70, then a load exactly on the boundary edge
      cycles(5);
      pulse_load(16'h0C70, 4'h0);
      cycles(13);
      val_i  = 16'h0070;
      dp_i   = 4'h0;
      load_i = 1'b1;
      @(negedge CP);
      load_i = 1'b0;
      check("f3_frame_on_time", 16'(frame_o), 16'd1);
      check("f3_new_pending", 16'(pend_o), 16'd1);
      push_frame(16'h0C70, 4'h0);
      wait_frame("f4");
      check("f4_pend_clr", 16'(pend_o), 16'd0);
      push_frame(16'h0070, 4'h0);

      // Drop en_i during dig2
      cycles(8);
      check("pre_dis_dig", 16'(dig_n_w), 16'b1101);
      en_i = 1'b0;
      skip_len = 1'b1;
      skip_gap = 1'b1;
      cycles(1);
      check("dis_dig", 16'(dig_n_w), 16'hF);
      check("dis_y", 16'(Y), 16'd0);
      sb_q.delete();
      push_frame(16'h0070, 4'h0);
      frame_snap = frame_cnt;
      cycles(3);
      en_i = 1'b1;
      cycles(8);
      check("no_frame_on_dis", 16'(frame_cnt), 16'(frame_snap));
      wait_frame("restart");
      push_frame(16'h0070, 4'h0);

      // Asynchronous reset during dig1
      cycles(3);
      #2 MR = 1'b0;
      #1;
      check("amr_dig", 16'(dig_n_w), 16'hF);
      check("amr_y", 16'(Y), 16'd0);
      check("amr_dp", 16'(dp), 16'd1);
      check("amr_pend", 16'(pend_o), 16'd0);
      skip_len = 1'b1;
      skip_gap = 1'b1;
      sb_q.delete();
      push_frame(16'h0000, 4'h0);
      frame_snap = frame_cnt;
      cycles(2);
      MR = 1'b1;
      cycles(8);
      check("no_frame_on_rst", 16'(frame_cnt), 16'(frame_snap));
      wait_frame("after_rst");
      check("sb_drained", 16'(sb_q.size()), 16'd0);
      en_i = 1'b0;
      cycles(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
